// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: sequential fetch on a req/gnt/rvalid bus, a small
// FIFO of {instruction, PC} pairs toward decode, and redirect handling that
// flushes the FIFO and drops responses to requests issued before the redirect.
module instruction_prefetch_unit #(
    parameter int XLEN            = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] start_addr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [XLEN-1:0]  WORD_STEP = XLEN'(4);
    localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_r;
    state_e           state_next_s;
    logic [XLEN-1:0]  fetch_pc_r;
    logic [XLEN-1:0]  resp_pc_r;
    logic [OUT_W-1:0] outstanding_r;
    logic [OUT_W-1:0] outstanding_next_s;
    logic [OUT_W-1:0] discard_r;
    logic [OUT_W-1:0] discard_next_s;
    logic [CNT_W-1:0] fifo_count_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [XLEN-1:0]  instr_mem_r [FIFO_DEPTH];
    logic [XLEN-1:0]  pc_mem_r    [FIFO_DEPTH];

    logic            run_s;
    logic            redirect_s;
    logic            fifo_empty_s;
    logic            credit_ok_s;
    logic            req_s;
    logic            grant_s;
    logic            rsp_s;
    logic            live_rsp_s;
    logic            if_valid_s;
    logic            pop_s;
    logic [XLEN-1:0] redirect_pc_s;
    logic [XLEN-1:0] start_pc_s;
    logic            unused_low_bits_s;

    // Low address bits are forced to a word boundary and never looked at.
    assign unused_low_bits_s = ^{redirect_pc_i[1:0], start_addr_i[1:0]};
    assign redirect_pc_s     = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign start_pc_s        = {start_addr_i[XLEN-1:2], 2'b00};

    assign run_s        = (state_r == ST_RUN);
    assign redirect_s   = run_s & redirect_i;
    assign fifo_empty_s = (fifo_count_r == '0);
    // A request is only issued when both an outstanding slot and a FIFO slot
    // are reserved for its response, so a live response can always be pushed.
    assign credit_ok_s  = (int'(outstanding_r) < MAX_OUTSTANDING) &&
                          ((int'(fifo_count_r) + int'(outstanding_r)) < FIFO_DEPTH);
    assign req_s        = run_s & ~redirect_i & credit_ok_s;
    assign grant_s      = req_s & imem_gnt_i;
    assign rsp_s        = run_s & imem_rvalid_i;
    assign live_rsp_s   = rsp_s & (discard_r == '0) & ~redirect_i;
    assign if_valid_s   = ~fifo_empty_s & ~redirect_i;
    assign pop_s        = if_valid_s & id_ready_i;

    assign imem_req_o  = req_s;
    assign imem_addr_o = fetch_pc_r;
    assign if_valid_o  = if_valid_s;
    assign instr_o     = fifo_empty_s ? '0 : instr_mem_r[rd_ptr_r];
    assign pc_o        = fifo_empty_s ? '0 : pc_mem_r[rd_ptr_r];

    // Next-state logic: BOOT lasts exactly one cycle, RUN holds until reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: state_next_s = ST_RUN;
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_BOOT;
        endcase
    end

    // Outstanding and discard counters; a redirect turns every request still
    // in flight after this cycle's response into one to be dropped.
    always_comb begin
        outstanding_next_s = outstanding_r;
        discard_next_s     = discard_r;
        if (grant_s && !rsp_s) begin
            outstanding_next_s = outstanding_r + OUT_ONE;
        end else if (!grant_s && rsp_s) begin
            outstanding_next_s = outstanding_r - OUT_ONE;
        end else begin
            outstanding_next_s = outstanding_r;
        end
        if (redirect_s) begin
            discard_next_s = outstanding_next_s;
        end else if (rsp_s && (discard_r != '0)) begin
            discard_next_s = discard_r - OUT_ONE;
        end else begin
            discard_next_s = discard_r;
        end
    end

    // State, fetch/response PCs and bus bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_BOOT;
            fetch_pc_r    <= '0;
            resp_pc_r     <= '0;
            outstanding_r <= '0;
            discard_r     <= '0;
        end else begin
            state_r       <= state_next_s;
            outstanding_r <= outstanding_next_s;
            discard_r     <= discard_next_s;
            if (state_r == ST_BOOT) begin
                fetch_pc_r <= start_pc_s;
                resp_pc_r  <= start_pc_s;
            end else if (redirect_i) begin
                fetch_pc_r <= redirect_pc_s;
                resp_pc_r  <= redirect_pc_s;
            end else begin
                if (grant_s) begin
                    fetch_pc_r <= fetch_pc_r + WORD_STEP;
                end
                if (live_rsp_s) begin
                    resp_pc_r <= resp_pc_r + WORD_STEP;
                end
            end
        end
    end

    // Prefetch FIFO: cleared on redirect, otherwise push live responses and
    // pop on transfer (both in one cycle keeps the count, even when full).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            fifo_count_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_r[i] <= '0;
                pc_mem_r[i]    <= '0;
            end
        end else if (redirect_s) begin
            rd_ptr_r     <= '0;
            wr_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else begin
            if (live_rsp_s) begin
                instr_mem_r[wr_ptr_r] <= imem_rdata_i;
                pc_mem_r[wr_ptr_r]    <= resp_pc_r;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (live_rsp_s && !pop_s) begin
                fifo_count_r <= fifo_count_r + CNT_ONE;
            end else if (!live_rsp_s && pop_s) begin
                fifo_count_r <= fifo_count_r - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Testbench for instruction_prefetch_unit: randomized bus/decode traffic checked
// cycle by cycle against a queue-based reference model, a table of scenarios,
// and directed sequences for back-pressure, redirects, wrap and mid-run reset.
module tb_instruction_prefetch_unit;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk;
    logic        reset;
    logic [31:0] start_addr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        id_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    instruction_prefetch_unit #(
        .XLEN(32), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset), .start_addr_i(start_addr_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o),
        .id_ready_i(id_ready_i), .instr_o(instr_o), .pc_o(pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side memory (tracks the DUT's real grants) and reference model.
    typedef struct packed { logic [31:0] addr; int gcyc; } mreq_t;
    typedef struct packed { logic [31:0] addr; logic live; } infl_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t mem_q[$];
    infl_t infl_q[$];
    ent_t  fifo_q[$];
    logic [31:0] m_fetch_pc;
    bit    m_boot;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gnt_pct, rv_pct, rdy_pct;
    bit dut_xfer;
    logic [31:0] dut_xfer_pc;

    typedef struct packed {
        logic [31:0] start;
        int          ncyc;
        int          gnt_pct;
        int          rv_pct;
        int          rdy_pct;
        int          redir_pct;
        logic [31:0] exp_first_pc;
    } vec_t;
    vec_t vecs[4];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_reset(input logic [31:0] start);
        reset         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        id_ready_i    = 1'b0;
        #1;
        chk("rst_req",   {31'h0, imem_req_o}, 32'h0);
        chk("rst_valid", {31'h0, if_valid_o}, 32'h0);
        chk("rst_pc",    pc_o,        32'h0);
        chk("rst_instr", instr_o,     32'h0);
        chk("rst_addr",  imem_addr_o, 32'h0);
        @(posedge clk); #1;
        start_addr_i = start;
        reset        = 1'b0;
        mem_q.delete();
        infl_q.delete();
        fifo_q.delete();
        m_fetch_pc = 32'h0;
        m_boot     = 1'b1;
    endtask

    // One clock cycle: drive inputs, predict outputs, compare at negedge, advance model.
    task automatic cycle(input bit redir, input logic [31:0] tgt);
        bit rv, exp_req, exp_val, grant, pop;
        logic [31:0] exp_pc, exp_instr;
        mreq_t mh;
        infl_t h;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        rv = (mem_q.size() > 0) && (mem_q[0].gcyc < cyc) && ($urandom_range(99) < rv_pct);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? data_of(mem_q[0].addr) : $urandom;
        id_ready_i    = ($urandom_range(99) < rdy_pct);

        exp_req   = !m_boot && !redir && (infl_q.size() < MAXO) &&
                    (fifo_q.size() + infl_q.size() < DEPTH);
        exp_val   = (fifo_q.size() > 0) && !redir;
        exp_pc    = (fifo_q.size() > 0) ? fifo_q[0].pc : 32'h0;
        exp_instr = (fifo_q.size() > 0) ? fifo_q[0].instr : 32'h0;

        @(negedge clk);
        chk("req",   {31'h0, imem_req_o}, {31'h0, exp_req});
        chk("addr",  imem_addr_o, m_fetch_pc);
        chk("valid", {31'h0, if_valid_o}, {31'h0, exp_val});
        chk("pc",    pc_o,    exp_pc);
        chk("instr", instr_o, exp_instr);
        dut_xfer    = if_valid_o && id_ready_i;
        dut_xfer_pc = pc_o;

        // bench memory follows the DUT's actual bus activity
        if (rv) mh = mem_q.pop_front();
        if (imem_req_o && imem_gnt_i) mem_q.push_back('{addr: imem_addr_o, gcyc: cyc});

        grant = exp_req && imem_gnt_i;
        pop   = exp_val && id_ready_i;
        if (m_boot) begin
            m_fetch_pc = {start_addr_i[31:2], 2'b00};
            m_boot     = 1'b0;
        end else begin
            if (pop) void'(fifo_q.pop_front());
            if (rv && infl_q.size() > 0) begin
                h = infl_q.pop_front();
                if (h.live && !redir) fifo_q.push_back('{pc: h.addr, instr: data_of(h.addr)});
            end
            if (redir) begin
                fifo_q.delete();
                foreach (infl_q[k]) infl_q[k].live = 1'b0;
                m_fetch_pc = {tgt[31:2], 2'b00};
            end else if (grant) begin
                infl_q.push_back('{addr: m_fetch_pc, live: 1'b1});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic set_pcts(input int g, input int r, input int d);
        gnt_pct = g;
        rv_pct  = r;
        rdy_pct = d;
    endtask

    // Waits (bounded) for a valid instruction after a redirect and checks its PC.
    task automatic wait_first(input string name, input logic [31:0] exp_pc);
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (if_valid_o && !redirect_i) begin
                found = 1'b1;
                break;
            end
            cycle(1'b0, 32'h0);
        end
        chk({name, "_found"}, {31'h0, found}, 32'h1);
        if (found) begin
            chk({name, "_pc"},    pc_o,    exp_pc);
            chk({name, "_instr"}, instr_o, data_of(exp_pc));
        end
    endtask

    initial begin
        vecs[0] = '{start: 32'h0000_0100, ncyc: 40,  gnt_pct: 100, rv_pct: 100, rdy_pct: 100, redir_pct: 0, exp_first_pc: 32'h0000_0100};
        vecs[1] = '{start: 32'h8000_0000, ncyc: 150, gnt_pct: 70,  rv_pct: 60,  rdy_pct: 50,  redir_pct: 5, exp_first_pc: 32'h8000_0000};
        vecs[2] = '{start: 32'h0000_1000, ncyc: 200, gnt_pct: 50,  rv_pct: 50,  rdy_pct: 70,  redir_pct: 8, exp_first_pc: 32'h0000_1000};
        vecs[3] = '{start: 32'hFFFF_FFF0, ncyc: 100, gnt_pct: 90,  rv_pct: 90,  rdy_pct: 30,  redir_pct: 0, exp_first_pc: 32'hFFFF_FFF0};

        reset         = 1'b0;
        start_addr_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        id_ready_i    = 1'b0;
        #2;

        // Table of randomized scenarios, each from a fresh reset.
        for (int v = 0; v < 4; v++) begin
            bit seen = 1'b0;
            bit any_redir = 1'b0;
            apply_reset(vecs[v].start);
            set_pcts(vecs[v].gnt_pct, vecs[v].rv_pct, vecs[v].rdy_pct);
            for (int i = 0; i < vecs[v].ncyc; i++) begin
                bit r = (i >= 20) && ($urandom_range(99) < vecs[v].redir_pct);
                any_redir = any_redir | r;
                cycle(r, $urandom);
                if (dut_xfer && !seen && !any_redir) begin
                    chk("first_pc", dut_xfer_pc, vecs[v].exp_first_pc);
                    seen = 1'b1;
                end
            end
        end

        // Back-pressure: FIFO fills to depth, requests stop, then in-order drain.
        apply_reset(32'h0000_0200);
        set_pcts(100, 100, 0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0);
        chk("full_req",   {31'h0, imem_req_o}, 32'h0);
        chk("full_valid", {31'h0, if_valid_o}, 32'h1);
        set_pcts(0, 100, 100);
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", pc_o, 32'h0000_0200 + 32'(4 * k));
            cycle(1'b0, 32'h0);
        end
        chk("drained_valid", {31'h0, if_valid_o}, 32'h0);

        // Redirect with two requests outstanding: both responses dropped.
        apply_reset(32'h0000_0300);
        set_pcts(100, 0, 100);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_2002);
        set_pcts(100, 100, 100);
        wait_first("redir2", 32'h0000_2000);

        // Redirect coinciding with a response and a would-be pop while streaming.
        apply_reset(32'h0000_0400);
        set_pcts(100, 100, 100);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_3001);
        wait_first("redir_rv", 32'h0000_3000);

        // Sequential fetch wraps from the top of the address space.
        apply_reset(32'hFFFF_FFFC);
        set_pcts(100, 0, 0);
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        chk("wrap_addr", imem_addr_o, 32'h0);
        set_pcts(100, 100, 100);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0);

        // Reset while two requests are outstanding, then restart elsewhere.
        apply_reset(32'h0000_0500);
        set_pcts(100, 0, 100);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0);
        apply_reset(32'h0000_0600);
        set_pcts(100, 100, 100);
        cycle(1'b0, 32'h0);
        chk("rerun_addr", imem_addr_o, 32'h0000_0600);
        chk("rerun_req",  {31'h0, imem_req_o}, 32'h1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
